// File: rtl/fg_rate_sequencer_if.sv
// Host-side divide-ratio update channel for the function-generator rate sequencer.
// The host drives Div_Val/Div_Req. The sequencer answers with Div_Ack/Div_Err pulses.
interface fg_rate_sequencer_if #(
  parameter int unsigned DIV_W = 16
) ();

  logic [DIV_W-1:0] Div_Val;
  logic             Div_Req;
  logic             Div_Ack;
  logic             Div_Err;

  modport master (
    output Div_Val,
    output Div_Req,
    input  Div_Ack,
    input  Div_Err
  );

  modport slave (
    input  Div_Val,
    input  Div_Req,
    output Div_Ack,
    output Div_Err
  );

endinterface

// File: rtl/fg_rate_sequencer.sv
// Run/stop and rate controller for function-generator sample timing.
// Emits Fg_En one cycle before Dac_En, once every active_div cycles.
// A new divide ratio is applied only on a period boundary.
module fg_rate_sequencer #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int unsigned MIN_DIV     = 2
) (
  input  logic                     Fg_CLK,
  input  logic                     Fg_RESET,
  input  logic                     Start,
  input  logic                     Stop,
  fg_rate_sequencer_if.slave       div_if,
  output logic                     Fg_En,
  output logic                     Dac_En,
  output logic                     Busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [DIV_W-1:0] reload_val;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             fg_en_q, fg_en_d;
  logic             dac_en_q, dac_en_d;
  logic             busy_q, busy_d;
  logic             period_end;
  logic             req_take;
  logic             div_ok;
  logic             resume;

  // Next-state, counter, ratio handshake and registered-output decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_div_d = active_div_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    fg_en_d      = 1'b0;
    dac_en_d     = 1'b0;
    busy_d       = 1'b0;

    period_end = (cnt_q == '0);
    resume     = Start && !Stop;
    div_ok     = (div_if.Div_Val >= DIV_W'(MIN_DIV));
    // A pending request is taken at any idle cycle, or on the last cycle of a period
    req_take   = div_if.Div_Req && !ack_q && ((state_q == IDLE) || period_end);

    if (req_take) begin
      ack_d = 1'b1;
      err_d = !div_ok;
      if (div_ok) begin
        active_div_d = div_if.Div_Val;
      end
    end

    reload_val = active_div_d - DIV_W'(1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (resume) begin
          state_d = RUN;
          cnt_d   = reload_val;
        end
      end

      RUN: begin
        if (Stop) begin
          state_d = STOP_PEND;
        end
        cnt_d = period_end ? reload_val : (cnt_q - DIV_W'(1));
      end

      STOP_PEND: begin
        // Resume keeps counting so the strobe train has no gap
        if (resume) begin
          state_d = RUN;
          cnt_d   = period_end ? reload_val : (cnt_q - DIV_W'(1));
        end else if (period_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d   = (state_d != IDLE);
    fg_en_d  = busy_d && (cnt_d == DIV_W'(1));
    dac_en_d = busy_d && (cnt_d == '0);
  end

  // State and output registers; reset drops any in-flight request
  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      active_div_q <= DIV_W'(DEFAULT_DIV);
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      fg_en_q      <= 1'b0;
      dac_en_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      fg_en_q      <= fg_en_d;
      dac_en_q     <= dac_en_d;
      busy_q       <= busy_d;
    end
  end

  assign Fg_En          = fg_en_q;
  assign Dac_En         = dac_en_q;
  assign Busy           = busy_q;
  assign div_if.Div_Ack = ack_q;
  assign div_if.Div_Err = err_q;

  // Strobes never overlap while the ratio is at least two
  a_strobe_excl : assert property (@(posedge Fg_CLK) disable iff (Fg_RESET)
    !(Fg_En && Dac_En));

  a_err_with_ack : assert property (@(posedge Fg_CLK) disable iff (Fg_RESET)
    div_if.Div_Err |-> div_if.Div_Ack);

  a_ack_single : assert property (@(posedge Fg_CLK) disable iff (Fg_RESET)
    div_if.Div_Ack |=> !div_if.Div_Ack);

endmodule
